// File: rtl/uart_tx_mmio_if.sv
// Data-store bus seen by the serial transmit peripheral: CPU store strobe,
// address and data in; gated DMEM write enable and status read port out.
interface uart_tx_mmio_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          MW;
  logic [AW-1:0] Address;
  logic [DW-1:0] Data_in;
  logic          dmem_MW;
  logic          rd_hit;
  logic [DW-1:0] rd_data;

  modport master (
    output MW, Address, Data_in,
    input  dmem_MW, rd_hit, rd_data
  );

  modport slave (
    input  MW, Address, Data_in,
    output dmem_MW, rd_hit, rd_data
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter: stores to TX_ADDR feed a small FIFO,
// other stores pass through to DMEM, status byte readable at STAT_ADDR.
module uart_tx_mmio #(
  parameter logic [7:0]  TX_ADDR      = 8'hFF,
  parameter logic [7:0]  STAT_ADDR    = 8'hFE,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_mmio_if.slave               bus,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_d;
  logic             pop;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             full, empty;
  logic             push_req, push_ok, clr_req;

  // Bus decode; fullness always judged on the pre-edge occupancy
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign push_req = bus.MW && (bus.Address == TX_ADDR);
  assign push_ok  = push_req && !full;
  assign clr_req  = bus.MW && (bus.Address == STAT_ADDR) && bus.Data_in[3];

  assign bus.dmem_MW = bus.MW && (bus.Address != TX_ADDR) && (bus.Address != STAT_ADDR);
  assign bus.rd_hit  = (bus.Address == STAT_ADDR);
  assign bus.rd_data = {4'b0000, overflow_q, busy, full, empty};

  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;

  // Transmit sequencer; tx_d is the line level of the state being entered
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          shreg_d = mem[head_q];
          pop     = 1'b1;
          tmr_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      DATA: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[idx_q + 3'd1];
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx      <= tx_d;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) tail_q <= tail_q + PTR_W'(1);
      if (pop)     head_q <= head_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && full) overflow_q <= 1'b1;
      else if (clr_req)     overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_q] <= bus.Data_in;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: decode vector table, scoreboarded serial frames,
// overflow, reset abort and FIFO wrap sequences.
module tb_uart_tx_mmio;
  localparam logic [7:0]  TX_ADDR   = 8'hFF;
  localparam logic [7:0]  STAT_ADDR = 8'hFE;
  localparam int unsigned CPB       = 4;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned FRAME     = 10 * CPB;
  localparam int unsigned GAP       = FRAME + 1;
  localparam int unsigned MAXF      = 64;

  logic       clk;
  logic       reset;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_mmio_if bif ();

  uart_tx_mmio #(
    .TX_ADDR     (TX_ADDR),
    .STAT_ADDR   (STAT_ADDR),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  int          rd_idx;
  logic [7:0]  exp_q[$];

  // Frame receiver: written only by the monitor process
  int unsigned cyc;
  int          rx_cnt;
  int          rx_starts;
  logic [7:0]  rx_byte  [MAXF];
  logic        rx_err   [MAXF];
  int unsigned rx_start [MAXF];

  initial begin : mon
    logic [FRAME-1:0] sh;
    logic [7:0]       byt;
    logic             err;
    int               c;
    bit               cap;
    int unsigned      st;
    cyc = 0; rx_cnt = 0; rx_starts = 0; cap = 0; c = 0; st = 0; sh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        cap = 0;
      end else if (!cap) begin
        if (tx == 1'b0) begin
          cap = 1; c = 1; sh = '0; st = cyc; rx_starts++;
        end
      end else begin
        sh[c] = tx;
        c++;
        if (c == int'(FRAME)) begin
          err = 1'b0;
          for (int s = 0; s < 10; s++)
            for (int j = 1; j < int'(CPB); j++)
              if (sh[s*CPB + j] !== sh[s*CPB]) err = 1'b1;
          if (sh[0] !== 1'b0) err = 1'b1;
          if (sh[9*CPB] !== 1'b1) err = 1'b1;
          for (int b = 0; b < 8; b++) byt[b] = sh[CPB*(b+1)];
          if (rx_cnt < int'(MAXF)) begin
            rx_byte[rx_cnt]  = byt;
            rx_err[rx_cnt]   = err;
            rx_start[rx_cnt] = st;
            rx_cnt++;
          end
          cap = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       mw;
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_dmem;
    logic       exp_hit;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    bif.MW = 1'b1; bif.Address = a; bif.Data_in = d;
    #1;
    check($sformatf("dmem_mw_store_%02h", a), bif.dmem_MW,
          (a != TX_ADDR) && (a != STAT_ADDR));
    step();
    bif.MW = 1'b0;
  endtask

  task automatic store_tx(input logic [7:0] d, input bit accept);
    if (accept) exp_q.push_back(d);
    store(TX_ADDR, d);
  endtask

  task automatic status(input string nm, input logic [7:0] exp);
    bif.Address = STAT_ADDR;
    #1;
    check({nm, "_hit"}, bif.rd_hit, 1'b1);
    check(nm, bif.rd_data, exp);
  endtask

  task automatic expect_frame(input string nm);
    logic [7:0] e;
    int n;
    n = 0;
    while (rx_cnt <= rd_idx && n < 200) begin step(); n++; end
    if (rx_cnt <= rd_idx) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no frame within 200 cycles, required one", nm);
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check({nm, "_byte"}, rx_byte[rd_idx], e);
      check({nm, "_framing"}, rx_err[rd_idx], 1'b0);
      rd_idx++;
    end
  endtask

  task automatic check_gaps(input string nm, input int first, input int last);
    for (int i = first + 1; i <= last; i++)
      check($sformatf("%s_gap%0d", nm, i - first), rx_start[i] - rx_start[i-1], GAP);
  endtask

  function automatic logic [7:0] s6_byte(input int i);
    return 8'(i * 29 + 7);
  endfunction

  initial begin : main
    int b;
    int n;
    int rs;
    int rc;
    checks = 0; failures = 0; rd_idx = 0;
    bif.MW = 1'b0; bif.Address = 8'h00; bif.Data_in = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    status("rst_status", 8'h01);

    // Combinational decode table, strobe removed before the edge
    vecs[0] = '{1'b1, 8'h10, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h10, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'hFF, 8'h55, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hFE, 8'h08, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'hFE, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'hAA, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'hFD, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'hFF, 8'h12, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bif.MW = vecs[i].mw; bif.Address = vecs[i].addr; bif.Data_in = vecs[i].data;
      #1;
      check($sformatf("vec%0d_dmem_mw", i), bif.dmem_MW, vecs[i].exp_dmem);
      check($sformatf("vec%0d_rd_hit", i), bif.rd_hit, vecs[i].exp_hit);
      if (vecs[i].exp_hit) check($sformatf("vec%0d_rd_data", i), bif.rd_data, 8'h01);
      bif.MW = 1'b0;
      step();
    end

    // Pass-through store leaves the transmitter alone
    rs = rx_starts;
    store(8'h10, 8'h3C);
    check("s4_count", fifo_count, 3'd0);
    check("s4_busy", busy, 1'b0);
    repeat (10) step();
    check("s4_tx", tx, 1'b1);
    check("s4_no_frame", rx_starts, rs);

    // Single byte: latency and exact frame
    store_tx(8'hA5, 1);
    check("s1_tx_after_push", tx, 1'b1);
    check("s1_count_after_push", fifo_count, 3'd1);
    check("s1_busy_after_push", busy, 1'b0);
    step();
    check("s1_tx_start", tx, 1'b0);
    check("s1_busy_start", busy, 1'b1);
    check("s1_count_popped", fifo_count, 3'd0);
    expect_frame("s1");
    check("s1_tx_end", tx, 1'b1);
    check("s1_busy_end", busy, 1'b0);

    // Six back-to-back pushes, last one overflows
    b = rd_idx;
    for (int i = 1; i <= 6; i++) store_tx(8'(i), i <= 5);
    check("s2_count_full", fifo_count, 3'd4);
    status("s2_status", 8'h0E);
    for (int i = 0; i < 5; i++) expect_frame($sformatf("s2_f%0d", i));
    check_gaps("s2", b, b + 4);
    status("s2_status_drained", 8'h09);

    // Overflow clear semantics
    store(STAT_ADDR, 8'hF7);
    status("s3_noclear_bit3_low", 8'h09);
    store(STAT_ADDR, 8'h08);
    status("s3_cleared", 8'h01);
    for (int i = 0; i < 6; i++) store_tx(8'h41 + 8'(i), i < 5);
    status("s3_ovf_set", 8'h0E);
    store(STAT_ADDR, 8'h08);
    status("s3_cleared_full", 8'h06);
    store_tx(8'h47, 0);
    status("s3_ovf_reset_by_push", 8'h0E);
    for (int i = 0; i < 5; i++) expect_frame($sformatf("s3_f%0d", i));
    store(STAT_ADDR, 8'h08);
    status("s3_final", 8'h01);

    // Reset in the middle of the second of three frames
    rs = rx_starts;
    store_tx(8'h11, 1);
    store_tx(8'h22, 1);
    store_tx(8'h33, 1);
    expect_frame("s5_f0");
    n = 0;
    while (rx_starts < rs + 2 && n < 100) begin step(); n++; end
    check("s5_second_started", rx_starts, rs + 2);
    repeat (12) step();
    check("s5_busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("s5_tx_after_reset", tx, 1'b1);
    check("s5_busy_after_reset", busy, 1'b0);
    check("s5_count_after_reset", fifo_count, 3'd0);
    rs = rx_starts;
    rc = rx_cnt;
    repeat (150) step();
    check("s5_no_more_starts", rx_starts, rs);
    check("s5_no_more_frames", rx_cnt, rc);
    check("s5_tx_idle", tx, 1'b1);

    // Push on the IDLE pop edge with count = DEPTH-1; wrap over 13 bytes
    b = rd_idx;
    for (int i = 0; i < 4; i++) store_tx(s6_byte(i), 1);
    check("s6_count_three", fifo_count, 3'd3);
    repeat (GAP - 3) step();
    for (int j = 0; j < 9; j++) begin
      check($sformatf("s6_idle_before_%0d", j), busy, 1'b0);
      check($sformatf("s6_count_before_%0d", j), fifo_count, 3'd3);
      store_tx(s6_byte(4 + j), 1);
      check($sformatf("s6_count_after_%0d", j), fifo_count, 3'd3);
      status($sformatf("s6_status_%0d", j), 8'h04);
      if (j < 8) repeat (GAP - 1) step();
    end
    for (int i = 0; i < 13; i++) expect_frame($sformatf("s6_f%0d", i));
    check_gaps("s6", b, b + 12);
    check("s6_final_count", fifo_count, 3'd0);
    check("s6_final_busy", busy, 1'b0);
    check("s6_final_tx", tx, 1'b1);
    status("s6_final_status", 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
